// File: rtl/baseline_pkg.sv
// Shared helpers for the baseline tracker: sum width, LFSR step and signed clamp.
package baseline_pkg;

  function automatic int sum_width(input int dw, input int log2_depth);
    return dw + log2_depth + 1;
  endfunction

  // Right-shift Galois step; taps only reach bits [w-2:0]. A zero result reloads the seed.
  function automatic logic [31:0] lfsr_next(input logic [31:0] r, input logic [31:0] taps,
                                            input logic [31:0] seed, input int w);
    logic [31:0] mask;
    logic [31:0] n;
    mask = (32'd1 << (w - 1)) - 32'd1;
    n = (r >> 1) ^ (r[0] ? (taps & mask) : 32'd0);
    return (n == 32'd0) ? seed : n;
  endfunction

  function automatic int sat_dw(input int v, input int dw);
    int hi;
    int lo;
    hi = (1 << (dw - 1)) - 1;
    lo = -(1 << (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/baseline_lfsr_timer.sv
// Random-interval sample timer: counts valid beats up to the LFSR value r, then steps r.
module baseline_lfsr_timer
  import baseline_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'h6800,
  parameter int                SEED      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              sample_evt,
  output logic [LFSR_W-1:0] r
);

  logic [LFSR_W-1:0] cnt;

  assign sample_evt = in_valid && (cnt == r);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      r   <= LFSR_W'(SEED);
    end else if (sample_evt) begin
      cnt <= '0;
      r   <= LFSR_W'(lfsr_next(32'(r), 32'(LFSR_TAPS), 32'(SEED), LFSR_W));
    end else if (in_valid) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/baseline_tracker.sv
// Moving-average baseline estimator/subtractor for a signed sample stream.
// Optional pulse gating is built when BLR_PULSE_GATE_EN is defined.
module baseline_tracker
  import baseline_pkg::*;
#(
  parameter int                DW         = 14,
  parameter int                LOG2_DEPTH = 8,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'h6800,
  parameter int                SEED       = 10,
  parameter int                GATE_THR   = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DW-1:0]     in_data,
  input  logic                     freeze,
  output logic                     out_valid,
  output logic signed [DW-1:0]     out_data,
  output logic signed [DW-1:0]     baseline,
  output logic                     warm,
  output logic [LFSR_W-1:0]        lfsr_out
);

  localparam int N  = 1 << LOG2_DEPTH;
  localparam int SW = sum_width(DW, LOG2_DEPTH);

  logic                   sample_evt;
  logic signed [DW-1:0]   mem [N];
  logic [LOG2_DEPTH-1:0]  wp;
  logic [LOG2_DEPTH:0]    fill;
  logic signed [SW-1:0]   sum;
  logic signed [SW-1:0]   in_ext;
  logic signed [SW-1:0]   old_ext;
  int                     diff;
  logic                   gate_ok;
  logic                   accept;

  baseline_lfsr_timer #(
    .LFSR_W   (LFSR_W),
    .LFSR_TAPS(LFSR_TAPS),
    .SEED     (SEED)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sample_evt(sample_evt),
    .r         (lfsr_out)
  );

  // fill saturates at N, so its top bit alone marks a full window
  assign warm     = fill[LOG2_DEPTH];
  assign baseline = warm ? DW'(sum >>> LOG2_DEPTH) : '0;
  assign in_ext   = SW'(in_data);
  assign old_ext  = warm ? SW'(mem[wp]) : '0;
  assign diff     = int'(in_data) - int'(baseline);

`ifdef BLR_PULSE_GATE_EN
  assign gate_ok = !warm || (((diff < 0) ? -diff : diff) <= GATE_THR);
`else
  logic gate_unused;
  assign gate_unused = ^GATE_THR;
  assign gate_ok     = 1'b1;
`endif

  assign accept = sample_evt && !freeze && gate_ok;

  // Buffer contents are never cleared; fill masks stale entries.
  always_ff @(posedge clk) begin
    if (accept) mem[wp] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      fill      <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        sum <= sum + in_ext - old_ext;
        wp  <= wp + 1'b1;
        if (!warm) fill <= fill + 1'b1;
      end
      out_valid <= in_valid;
      if (in_valid) out_data <= DW'(sat_dw(diff, DW));
    end
  end

endmodule

// File: tb/tb_baseline_tracker.sv
// Directed bench for baseline_tracker (small LFSR so event intervals stay short).
module tb_baseline_tracker;

  localparam int DW   = 14;
  localparam int L2D  = 4;
  localparam int LW   = 5;
  localparam int SEED = 10;
  localparam int THR  = 512;
  localparam logic [LW-1:0] TAPS = 5'h0C;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 freeze;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic signed [DW-1:0] baseline;
  logic                 warm;
  logic [LW-1:0]        lfsr_out;

  int n_pass  = 0;
  int n_total = 0;
  int m_cnt;
  int m_r;
  bit last_evt;

  baseline_tracker #(
    .DW(DW), .LOG2_DEPTH(L2D), .LFSR_W(LW), .LFSR_TAPS(TAPS), .SEED(SEED), .GATE_THR(THR)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .freeze(freeze),
    .out_valid(out_valid), .out_data(out_data), .baseline(baseline), .warm(warm),
    .lfsr_out(lfsr_out)
  );

  always #5 clk = ~clk;

  function automatic int ref_next(input int r);
    int n;
    n = (r >> 1) ^ (((r & 1) != 0) ? (int'(TAPS) & ((1 << (LW - 1)) - 1)) : 0);
    return (n == 0) ? SEED : n;
  endfunction

  task automatic beat(input bit v, input int d, input bit f);
    in_valid = v;
    in_data  = DW'(d);
    freeze   = f;
    @(posedge clk);
    last_evt = v && (m_cnt == m_r);
    if (last_evt) begin
      m_cnt = 0;
      m_r   = ref_next(m_r);
    end else if (v) begin
      m_cnt++;
    end
    #1;
  endtask

  task automatic to_event(input int d, input bit f, output int beats);
    beats = 0;
    do begin
      beat(1'b1, d, f);
      beats++;
    end while (!last_evt);
  endtask

  task automatic do_reset(input bit v);
    rst      = 1'b1;
    in_valid = v;
    in_data  = DW'(1000);
    freeze   = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    m_cnt    = 0;
    m_r      = SEED;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0d want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 0) $display("FAIL reset_out_data got %0d want 0", out_data); else n_pass++;
    n_total++; if (baseline !== 0) $display("FAIL reset_baseline got %0d want 0", baseline); else n_pass++;
    n_total++; if (warm !== 1'b0) $display("FAIL reset_warm got %0d want 0", warm); else n_pass++;
    n_total++; if (lfsr_out !== LW'(SEED)) $display("FAIL reset_lfsr got %0d want %0d", lfsr_out, SEED); else n_pass++;
  endtask

  // Constant 100 input from a fresh reset: warm and baseline flip on the 16th accepted sample.
  task automatic test_warmup();
    int b;
    for (int k = 1; k <= 16; k++) begin
      to_event(100, 1'b0, b);
      if (k == 1) begin
        n_total++; if (b !== 11) $display("FAIL warm_first_evt_beat got %0d want 11", b); else n_pass++;
      end
      n_total++; if (out_data !== 100) $display("FAIL warm_out k=%0d got %0d want 100", k, out_data); else n_pass++;
      n_total++; if (warm !== (k == 16)) $display("FAIL warm_flag k=%0d got %0d want %0d", k, warm, k == 16); else n_pass++;
      n_total++; if (baseline !== ((k == 16) ? 100 : 0))
        $display("FAIL warm_baseline k=%0d got %0d want %0d", k, baseline, (k == 16) ? 100 : 0); else n_pass++;
      n_total++; if (lfsr_out !== LW'(m_r)) $display("FAIL warm_lfsr k=%0d got %0d want %0d", k, lfsr_out, m_r); else n_pass++;
    end
    beat(1'b1, 100, 1'b1);
    n_total++; if (out_data !== 0) $display("FAIL warm_out_after got %0d want 0", out_data); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL warm_out_valid got %0d want 1", out_valid); else n_pass++;
  endtask

  task automatic test_lfsr_seq();
    int b;
    for (int i = 0; i < 1000; i++) begin
      to_event(0, 1'b1, b);
      n_total++; if (lfsr_out !== LW'(m_r)) $display("FAIL lfsr_seq evt=%0d got %0d want %0d", i, lfsr_out, m_r); else n_pass++;
    end
    n_total++; if (baseline !== 100) $display("FAIL lfsr_seq_frozen_baseline got %0d want 100", baseline); else n_pass++;
  endtask

  task automatic test_idle();
    int b;
    int saved;
    beat(1'b1, 250, 1'b1);
    n_total++; if (out_data !== 150) $display("FAIL idle_pre_out got %0d want 150", out_data); else n_pass++;
    saved = m_r;
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 7000, 1'b0);
      n_total++; if (out_valid !== 1'b0) $display("FAIL idle_out_valid got %0d want 0", out_valid); else n_pass++;
      n_total++; if (out_data !== 150) $display("FAIL idle_out_hold got %0d want 150", out_data); else n_pass++;
      n_total++; if (lfsr_out !== LW'(saved)) $display("FAIL idle_lfsr_hold got %0d want %0d", lfsr_out, saved); else n_pass++;
    end
    to_event(250, 1'b1, b);
    n_total++; if (lfsr_out !== LW'(m_r)) $display("FAIL idle_resume_lfsr got %0d want %0d", lfsr_out, m_r); else n_pass++;
  endtask

  task automatic test_saturation();
    int b;
    do_reset(1'b0);
    for (int k = 0; k < 16; k++) to_event(-8000, 1'b0, b);
    n_total++; if (baseline !== -8000) $display("FAIL sat_base_neg got %0d want -8000", baseline); else n_pass++;
    beat(1'b1, 8000, 1'b1);
    n_total++; if (out_data !== 8191) $display("FAIL sat_pos got %0d want 8191", out_data); else n_pass++;
    beat(1'b1, 100, 1'b1);
    n_total++; if (out_data !== 8100) $display("FAIL sat_pos_inrange got %0d want 8100", out_data); else n_pass++;
    for (int k = 1; k <= 16; k++) begin
      to_event(8000, 1'b0, b);
      if (k == 8) begin
        n_total++; if (baseline !== 0) $display("FAIL sat_half_replaced got %0d want 0", baseline); else n_pass++;
      end
    end
    n_total++; if (baseline !== 8000) $display("FAIL sat_base_pos got %0d want 8000", baseline); else n_pass++;
    beat(1'b1, -8000, 1'b1);
    n_total++; if (out_data !== -8192) $display("FAIL sat_neg got %0d want -8192", out_data); else n_pass++;
    beat(1'b1, 100, 1'b1);
    n_total++; if (out_data !== -7900) $display("FAIL sat_neg_inrange got %0d want -7900", out_data); else n_pass++;
  endtask

  // Window holds 16 x 8000 on entry; frozen zeros must leave it intact.
  task automatic test_freeze();
    int b;
    int e;
    e = m_r;
    for (int k = 0; k < 5; k++) begin
      to_event(0, 1'b1, b);
      e = ref_next(e);
    end
    n_total++; if (baseline !== 8000) $display("FAIL freeze_baseline got %0d want 8000", baseline); else n_pass++;
    n_total++; if (lfsr_out !== LW'(e)) $display("FAIL freeze_lfsr_steps got %0d want %0d", lfsr_out, e); else n_pass++;
    to_event(0, 1'b0, b);
    n_total++; if (out_data !== -8000) $display("FAIL unfreeze_out got %0d want -8000", out_data); else n_pass++;
    n_total++; if (baseline !== 7500) $display("FAIL unfreeze_baseline got %0d want 7500", baseline); else n_pass++;
  endtask

  task automatic test_gate();
    int b;
    do_reset(1'b0);
    for (int k = 0; k < 16; k++) to_event(0, 1'b0, b);
    n_total++; if (baseline !== 0) $display("FAIL gate_base0 got %0d want 0", baseline); else n_pass++;
    to_event(600, 1'b0, b);
    n_total++; if (out_data !== 600) $display("FAIL gate_out600 got %0d want 600", out_data); else n_pass++;
`ifdef BLR_PULSE_GATE_EN
    n_total++; if (baseline !== 0) $display("FAIL gate_reject600 got %0d want 0", baseline); else n_pass++;
    to_event(500, 1'b0, b);
    n_total++; if (baseline !== 31) $display("FAIL gate_accept500 got %0d want 31", baseline); else n_pass++;
    to_event(543, 1'b0, b);
    n_total++; if (baseline !== 65) $display("FAIL gate_accept_at_thr got %0d want 65", baseline); else n_pass++;
`else
    n_total++; if (baseline !== 37) $display("FAIL nogate_accept600 got %0d want 37", baseline); else n_pass++;
    to_event(500, 1'b0, b);
    n_total++; if (baseline !== 68) $display("FAIL nogate_accept500 got %0d want 68", baseline); else n_pass++;
    to_event(543, 1'b0, b);
    n_total++; if (baseline !== 102) $display("FAIL nogate_accept543 got %0d want 102", baseline); else n_pass++;
`endif
  endtask

  task automatic test_midrun_reset();
    n_total++; if (warm !== 1'b1) $display("FAIL mid_pre_warm got %0d want 1", warm); else n_pass++;
    do_reset(1'b1);
    n_total++; if (warm !== 1'b0) $display("FAIL mid_warm got %0d want 0", warm); else n_pass++;
    n_total++; if (baseline !== 0) $display("FAIL mid_baseline got %0d want 0", baseline); else n_pass++;
    n_total++; if (lfsr_out !== LW'(SEED)) $display("FAIL mid_lfsr got %0d want %0d", lfsr_out, SEED); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid got %0d want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 0) $display("FAIL mid_out_data got %0d want 0", out_data); else n_pass++;
    test_warmup();
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    freeze   = 1'b0;
    m_cnt    = 0;
    m_r      = SEED;
    last_evt = 1'b0;
    test_reset();
    test_warmup();
    test_lfsr_seq();
    test_idle();
    test_saturation();
    test_freeze();
    test_gate();
    test_midrun_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
